// File: rtl/micro_pkg.sv
// Shared definitions for the SimpleMicro multiply/divide tile: state encoding,
// default operand widths and the iteration-counter width helper.
package micro_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH_N = 8;
  localparam int DEF_WIDTH_D = 4;

  // Counter must hold the value WIDTH_N itself, hence the +1.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DEF_CNT_W = count_width(DEF_WIDTH_N);

endpackage

// File: rtl/micro_div_datapath.sv
// Restoring-divider datapath: Q/R/D registers plus one shift/compare/subtract step
// per enabled cycle. The partial remainder is stored in WIDTH_D bits because it is always below D.
module micro_div_datapath
  import micro_pkg::*;
#(
  parameter int WIDTH_N = DEF_WIDTH_N,
  parameter int WIDTH_D = DEF_WIDTH_D
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH_N-1:0] dividend_i,
  input  logic [WIDTH_D-1:0] divisor_i,
  output logic               ge_o,
  output logic [WIDTH_N-2:0] q_keep_o,
  output logic [WIDTH_D-1:0] r_nxt_o
);

  logic [WIDTH_N-1:0] q_q, q_d;
  logic [WIDTH_D-1:0] r_q, r_d;
  logic [WIDTH_D-1:0] d_q;
  logic [WIDTH_D:0]   r_shift;
  logic               ge;

  // One restoring step: the WIDTH_D+1-bit compare decides, the low bits carry the difference.
  always_comb begin
    r_shift = {r_q, q_q[WIDTH_N-1]};
    ge      = (r_shift >= {1'b0, d_q});
    if (ge) begin
      r_d = r_shift[WIDTH_D-1:0] - d_q;
    end else begin
      r_d = r_shift[WIDTH_D-1:0];
    end
    q_d = {q_q[WIDTH_N-2:0], ge};
  end

  assign ge_o     = ge;
  assign q_keep_o = q_q[WIDTH_N-2:0];
  assign r_nxt_o  = r_d;

  // Operand capture on load, iteration on step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= {WIDTH_N{1'b0}};
      r_q <= {WIDTH_D{1'b0}};
      d_q <= {WIDTH_D{1'b0}};
    end else if (load_i) begin
      q_q <= dividend_i;
      r_q <= {WIDTH_D{1'b0}};
      d_q <= divisor_i;
    end else if (step_i) begin
      q_q <= q_d;
      r_q <= r_d;
    end
  end

endmodule

// File: rtl/micro_div_njp.sv
// Sequential restoring divider: control FSM, iteration counter and registered
// result outputs around micro_div_datapath, with start/done framing shared with the multiplier.
module micro_div_njp
  import micro_pkg::*;
#(
  parameter int WIDTH_N = DEF_WIDTH_N,
  parameter int WIDTH_D = DEF_WIDTH_D
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder
);

  localparam int CNT_W = count_width(WIDTH_N);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [WIDTH_N-1:0] quot_q, quot_d;
  logic [WIDTH_D-1:0] rem_q, rem_d;
  logic               load, step, ge;
  logic [WIDTH_N-2:0] q_keep;
  logic [WIDTH_D-1:0] r_nxt;

  micro_div_datapath #(
    .WIDTH_N(WIDTH_N),
    .WIDTH_D(WIDTH_D)
  ) u_dp (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .load_i    (load),
    .step_i    (step),
    .dividend_i(dividend),
    .divisor_i (divisor),
    .ge_o      (ge),
    .q_keep_o  (q_keep),
    .r_nxt_o   (r_nxt)
  );

  // Next-state, counter and result-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor != {WIDTH_D{1'b0}}) begin
            state_d = RUN;
            load    = 1'b1;
            cnt_d   = CNT_W'(WIDTH_N);
            busy_d  = 1'b1;
            dz_d    = 1'b0;
          end else begin
            state_d = DONE;
            cnt_d   = {CNT_W{1'b0}};
            done_d  = 1'b1;
            dz_d    = 1'b1;
            quot_d  = {WIDTH_N{1'b1}};
            rem_d   = {WIDTH_D{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        // Final step: latch the step result directly so done appears with no extra cycle.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          dz_d    = 1'b0;
          quot_d  = {q_keep, ge};
          rem_d   = r_nxt;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= {WIDTH_N{1'b0}};
      rem_q   <= {WIDTH_D{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_micro_div_njp.sv
// Self-checking bench for micro_div_njp: a cycle-level behavioural model compared
// on every falling edge, plus directed vectors with hand-computed results.
module tb_micro_div_njp;

  localparam int WN = 8;
  localparam int WD = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          start;
  logic [WN-1:0] dividend;
  logic [WD-1:0] divisor;
  logic          busy, done, div_zero;
  logic [WN-1:0] quotient;
  logic [WD-1:0] remainder;

  int checks = 0;
  int passes = 0;

  always #5 sys_clk = ~sys_clk;

  micro_div_njp #(.WIDTH_N(WN), .WIDTH_D(WD)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .quotient (quotient),
    .remainder(remainder)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // Model: an accepted start either finishes at once (divisor 0) or WN edges later.
  int            cyc_left = 0;
  int            m_n, m_d;
  logic          e_busy, e_done, e_dz;
  logic [WN-1:0] e_q;
  logic [WD-1:0] e_r;

  initial begin
    forever begin
      @(posedge sys_clk);
      if (sys_rst) begin
        cyc_left = 0;
        e_busy = 1'b0; e_done = 1'b0; e_dz = 1'b0; e_q = '0; e_r = '0;
      end else begin
        e_done = 1'b0;
        if (cyc_left > 0) begin
          cyc_left--;
          if (cyc_left == 0) begin
            e_done = 1'b1;
            e_q    = WN'(m_n / m_d);
            e_r    = WD'(m_n % m_d);
            e_dz   = 1'b0;
          end
        end else if (start) begin
          m_n  = int'(dividend);
          m_d  = int'(divisor);
          e_dz = 1'b0;
          if (m_d == 0) begin
            e_done = 1'b1;
            e_q    = {WN{1'b1}};
            e_r    = '0;
            e_dz   = 1'b1;
          end else begin
            cyc_left = WN;
          end
        end
        e_busy = (cyc_left > 0);
      end
      @(negedge sys_clk);
      chk("busy",      32'(busy),      32'(e_busy));
      chk("done",      32'(done),      32'(e_done));
      chk("div_zero",  32'(div_zero),  32'(e_dz));
      chk("quotient",  32'(quotient),  32'(e_q));
      chk("remainder", 32'(remainder), 32'(e_r));
    end
  end

  task automatic idle(input int k);
    start = 1'b0;
    repeat (k) @(negedge sys_clk);
  endtask

  // Called at a falling edge; returns at the falling edge where done is seen.
  task automatic run_op(input int n, input int d, input bit hand,
                        input int eq, input int er, input int edz);
    int lat;
    bit seen;
    start    = 1'b1;
    dividend = WN'(n);
    divisor  = WD'(d);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge sys_clk);
      lat++;
      if (done) seen = 1'b1;
      else start = 1'b0;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), (d == 0) ? 32'd1 : 32'(WN + 1));
    if (hand) begin
      chk("hand_quotient",  32'(quotient),  32'(eq));
      chk("hand_remainder", 32'(remainder), 32'(er));
      chk("hand_div_zero",  32'(div_zero),  32'(edz));
    end
  endtask

  initial begin
    int ndone;
    sys_rst  = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge sys_clk);
    chk("reset_busy",     32'(busy),      32'd0);
    chk("reset_done",     32'(done),      32'd0);
    chk("reset_quotient", 32'(quotient),  32'd0);
    sys_rst = 1'b0;
    idle(1);

    run_op(200, 7, 1'b1, 28, 4, 0);
    idle(2);
    run_op(255, 15, 1'b1, 17, 0, 0);
    run_op(255, 1, 1'b1, 255, 0, 0);
    run_op(3, 15, 1'b1, 0, 3, 0);
    idle(2);
    run_op(100, 0, 1'b1, 255, 0, 1);
    run_op(13, 5, 1'b1, 2, 3, 0);
    run_op(100, 9, 1'b1, 11, 1, 0);
    idle(2);

    // Start pulsed mid-RUN must be ignored.
    start = 1'b1; dividend = 8'd13; divisor = 4'd5;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (3) @(negedge sys_clk);
    start = 1'b1; dividend = 8'd9; divisor = 4'd2;
    @(negedge sys_clk);
    start = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge sys_clk);
      if (done) ndone++;
    end
    chk("ignored_start_dones", 32'(ndone), 32'd1);
    chk("ignored_start_q", 32'(quotient), 32'd2);
    chk("ignored_start_r", 32'(remainder), 32'd3);

    // Reset in the middle of 200 / 7.
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("midrst_busy",     32'(busy),     32'd0);
    chk("midrst_done",     32'(done),     32'd0);
    chk("midrst_quotient", 32'(quotient), 32'd0);
    chk("midrst_rem",      32'(remainder), 32'd0);
    // Start together with reset: reset wins.
    start = 1'b1;
    @(negedge sys_clk);
    chk("rst_and_start_busy", 32'(busy), 32'd0);
    sys_rst = 1'b0;
    start   = 1'b0;
    idle(2);
    run_op(200, 7, 1'b1, 28, 4, 0);
    idle(1);

    for (int n = 0; n < 256; n++) begin
      for (int d = 0; d < 16; d++) begin
        run_op(n, d, 1'b0, 0, 0, 0);
      end
    end
    idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/micro_div_njp.md
# micro_div_njp

Sequential restoring divider that reverses the SimpleMicro multiply path. It takes an 8-bit dividend (same width as the multiplier product) and a 4-bit divisor (same width as the multiplier operands), and returns an 8-bit quotient and a 4-bit remainder. It sits beside the multiplier in the tile: its control/datapath split and start/done framing match, so the top-level wrapper can mux either unit onto the output pins.

## Interface
Parameters:
- WIDTH_N, default 8: dividend and quotient width.
- WIDTH_D, default 4: divisor and remainder width. Must be less than or equal to WIDTH_N.

Ports:
- sys_clk, input, 1: the single clock; all state changes on its rising edge.
- sys_rst, input, 1: reset. Synchronous, active-high.
- start, input, 1: request a division. Sampled only when busy is 0.
- dividend, input, WIDTH_N: numerator. Captured on an accepted start.
- divisor, input, WIDTH_D: denominator. Captured on an accepted start.
- busy, output, 1: high while iterating.
- done, output, 1: one-cycle pulse when results are valid.
- div_zero, output, 1: the last operation had divisor 0. Held until the next accepted start.
- quotient, output, WIDTH_N: result. Held until the next done.
- remainder, output, WIDTH_D: result. Held until the next done.

## Operation
- FSM states:
  - IDLE to RUN on start when divisor is nonzero.
  - IDLE to DONE on start when divisor is 0.
  - RUN to DONE when the iteration counter reaches 0.
  - DONE to IDLE, or DONE to RUN/DONE directly if start is high in the DONE cycle (back-to-back accepted).
- Accepted start:
  - Loads Q = dividend, D = divisor, R = 0 (WIDTH_D+1 bits), count = WIDTH_N.
  - Clears div_zero.
- RUN step, one per cycle:
  - R' = {R[WIDTH_D-1:0], Q[MSB]}, then Q = Q<<1.
  - If R' ≥ {0,D}: R = R' − D and Q[0] = 1.
  - Otherwise: R = R' and Q[0] = 0.
  - count decrements.
- Entering DONE from RUN: quotient ← Q, remainder ← R[WIDTH_D-1:0], div_zero = 0.
- Entering DONE from divide-by-zero: quotient ← all ones, remainder ← 0, div_zero = 1.
- start is ignored while busy is 1. Operand inputs are don't-care except in the accept cycle.
- All arithmetic is unsigned. The R width of WIDTH_D+1 prevents overflow of the compare.

## Timing
- Reset values: state IDLE, busy 0, done 0, div_zero 0, quotient 0, remainder 0, internal Q/R/D/count 0.
- Start accepted at edge T, nonzero divisor:
  - busy is 1 for cycles T+1 .. T+WIDTH_N.
  - done is 1 and results are updated in cycle T+WIDTH_N+1, with busy 0.
  - Latency is WIDTH_N+1 cycles (9 at default).
- Divisor 0: done and div_zero are visible at T+1, busy never rises, latency 1.
- Back-to-back: start high during the done cycle is accepted. busy rises in the next cycle, and the previous results stay on quotient/remainder until the new done.
- Reset asserted mid-RUN: the operation aborts, there is no done pulse, and all outputs return to reset values on the next edge.
- start and sys_rst asserted together: reset wins.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package (micro_pkg):
  - State enum: IDLE, RUN, DONE.
  - Default WIDTH_N/WIDTH_D constants, shared with the multiplier.
  - The count width, ceil(log2(WIDTH_N+1)).
- One sub-module, micro_div_datapath, holding the Q/R/D registers and the shift/compare/subtract step. It has load and step enables and a ge flag back to the FSM.
- The FSM, counter and output registers stay in micro_div_njp, mirroring the multiplier's control-unit/datapath split.

## Test plan
- Basic division: dividend 200, divisor 7, start at T → busy T+1..T+8; done at T+9 with quotient 28, remainder 4, div_zero 0.
- Maximum operands:
  - 255 / 15 → quotient 17, remainder 0.
  - 255 / 1 → quotient 255, remainder 0.
  - 3 / 15 → quotient 0, remainder 3.
- Divide by zero: 100 / 0 → done at T+1 with quotient 0xFF, remainder 0, div_zero 1, and busy never high. A following 13 / 5 clears div_zero and gives quotient 2, remainder 3.
- Back-to-back and ignored start:
  - 13 / 5, then start (100 / 9) raised during the done cycle → second done 9 cycles later with quotient 11, remainder 1.
  - start pulsed mid-RUN → ignored, with no extra done.
- Reset mid-operation: sys_rst high at cycle T+4 of 200 / 7 → next cycle all outputs are 0, no done; a fresh 200 / 7 afterwards completes correctly.
- Exhaustive sweep: all 256×16 operand pairs checked against the reference model (q = n/d, r = n%d; for d=0, 0xFF/0 with div_zero). Check done latency and busy timing on every pair.
